arbiter_fixed_buffered: RTL

ARBITER_FIXED_BUFFERED -- requirements
Module: arbiter_fixed_buffered

---
 rtl/arbiter_fixed_buffered.sv | 81 ++++++++
 1 files changed

// File: rtl/arbiter_fixed_buffered.sv
// Fixed-priority N:1 arbiter (lowest index wins) into a 2-entry {data, src} buffer; 1-cycle push-to-output latency.
// in_ready follows the grant while fewer than two entries are held, and never looks at out_ready.
module arbiter_fixed_buffered #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            in_valid,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  output logic [N-1:0]            in_ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [IDX_W-1:0]        out_src,
  input  logic                    out_ready
);

  logic [1:0]            r_count;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [DATA_WIDTH-1:0] r_data [2];
  logic [IDX_W-1:0]      r_src  [2];

  logic [N-1:0]          w_grant;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_din;
  logic                  w_seen;
  logic                  w_push;
  logic                  w_pop;

  // Lowest-numbered requester wins; its payload is muxed alongside the grant.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_din   = '0;
    w_seen  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && !w_seen) begin
        w_grant[i] = 1'b1;
        w_idx      = IDX_W'(i);
        w_din      = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      w_seen = w_seen | in_valid[i];
    end
  end

  assign in_ready  = (rst || r_count == 2'd2) ? '0 : w_grant;
  assign w_push    = |(in_valid & in_ready);
  assign out_valid = (r_count != 2'd0);
  assign w_pop     = out_valid & out_ready;
  assign out_data  = r_data[r_rptr];
  assign out_src   = r_src[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_src[0]  <= '0;
      r_src[1]  <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= w_din;
        r_src[r_wptr]  <= w_idx;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
